// File: rtl/cnn_ctrl_pkg.sv
// Shared types and helpers for the convolution window controller.
// The window-count helper gives the number of legal kernel positions in one frame.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned win_count(input int unsigned w, input int unsigned h,
                                              input int unsigned k, input int unsigned s);
        return ((h - k) / s + 1) * ((w - k) / s + 1);
    endfunction

endpackage

// File: rtl/window_pos_tracker.sv
// Follows the raster position of pushed pixels and flags beats that close a legal,
// stride-aligned kernel window, together with that window's output-map coordinates.
module window_pos_tracker
    import cnn_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         beat,
    output logic                         completes_window,
    output logic [cw(COLUMN_SIZE)-1:0]   win_row,
    output logic [cw(ROW_SIZE)-1:0]      win_col
);
    localparam int RW = cw(COLUMN_SIZE);
    localparam int CW = cw(ROW_SIZE);
    localparam int SW = cw(STRIDE);

    logic [RW-1:0] r_reg;
    logic [CW-1:0] c_reg;
    logic [SW-1:0] rph_reg;
    logic [SW-1:0] cph_reg;
    logic [RW-1:0] wr_reg;
    logic [CW-1:0] wc_reg;
    logic          row_end;
    logic          frame_end;
    logic          row_ok;
    logic          col_ok;

    // Phase counters sit at zero on every stride-aligned row/column past the kernel edge.
    assign row_end          = (c_reg == CW'(ROW_SIZE - 1));
    assign frame_end        = row_end && (r_reg == RW'(COLUMN_SIZE - 1));
    assign row_ok           = (r_reg >= RW'(KERNEL_SIZE - 1)) && (rph_reg == '0);
    assign col_ok           = (c_reg >= CW'(KERNEL_SIZE - 1)) && (cph_reg == '0);
    assign completes_window = beat && row_ok && col_ok;
    assign win_row          = wr_reg;
    assign win_col          = wc_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_reg   <= '0;
            c_reg   <= '0;
            rph_reg <= '0;
            cph_reg <= '0;
            wr_reg  <= '0;
            wc_reg  <= '0;
        end else if (beat) begin
            if (row_end) begin
                c_reg   <= '0;
                cph_reg <= '0;
                wc_reg  <= '0;
                if (frame_end) begin
                    r_reg   <= '0;
                    rph_reg <= '0;
                    wr_reg  <= '0;
                end else begin
                    r_reg <= r_reg + 1'b1;
                    if (r_reg < RW'(KERNEL_SIZE - 1))
                        rph_reg <= '0;
                    else if (rph_reg == '0)
                        rph_reg <= SW'(STRIDE - 1);
                    else
                        rph_reg <= rph_reg - 1'b1;
                    if (row_ok)
                        wr_reg <= wr_reg + 1'b1;
                end
            end else begin
                c_reg <= c_reg + 1'b1;
                if (c_reg < CW'(KERNEL_SIZE - 1))
                    cph_reg <= '0;
                else if (cph_reg == '0)
                    cph_reg <= SW'(STRIDE - 1);
                else
                    cph_reg <= cph_reg - 1'b1;
                if (completes_window)
                    wc_reg <= wc_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_controller.sv
// Frame sequencer: reads a frame from pixel RAM in raster order, streams it into the
// Image_Buffer and announces each legal window with its output-map coordinates.
module conv_window_controller
    import cnn_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int WIN_LATENCY = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   pause,
    output logic                                   mem_rd_en,
    output logic [cw(ROW_SIZE*COLUMN_SIZE)-1:0]    mem_addr,
    input  logic [DATA_SIZE-1:0]                   mem_rd_data,
    output logic [DATA_SIZE-1:0]                   buf_data,
    output logic                                   buf_data_valid,
    output logic                                   win_valid,
    output logic [cw(COLUMN_SIZE)-1:0]             win_row,
    output logic [cw(ROW_SIZE)-1:0]                win_col,
    output logic                                   busy,
    output logic                                   frame_done
);
    localparam int NPIX = ROW_SIZE * COLUMN_SIZE;
    localparam int AW   = cw(NPIX);
    localparam int RW   = cw(COLUMN_SIZE);
    localparam int CW   = cw(ROW_SIZE);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } win_beat_t;

    ctrl_state_t               state_reg;
    ctrl_state_t               state_next;
    logic [AW-1:0]             issue_cnt_reg;
    logic                      rd_pending_reg;
    logic                      last_issue;
    logic                      pipe_empty;
    logic                      clear;
    logic [WIN_LATENCY-1:0]    win_busy;
    win_beat_t                 win_in;

    assign last_issue = (issue_cnt_reg == AW'(NPIX - 1));
    assign pipe_empty = !rd_pending_reg && !buf_data_valid && !(|win_busy);

    always_ff @(posedge clock) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = FEED;
            FEED:    if (mem_rd_en && last_issue) state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en  = (state_reg == FEED) && !pause;
        mem_addr   = mem_rd_en ? issue_cnt_reg : '0;
        busy       = (state_reg != IDLE);
        frame_done = (state_reg == DRAIN) && pipe_empty;
        clear      = (state_reg == IDLE) && start;
    end

    // Read strobe is delayed twice: once for the RAM latency, once for the buf_data register.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_cnt_reg  <= '0;
            rd_pending_reg <= 1'b0;
            buf_data_valid <= 1'b0;
            buf_data       <= '0;
        end else begin
            if (mem_rd_en)
                issue_cnt_reg <= last_issue ? '0 : issue_cnt_reg + 1'b1;
            rd_pending_reg <= mem_rd_en;
            buf_data_valid <= rd_pending_reg;
            if (rd_pending_reg)
                buf_data <= mem_rd_data;
        end
    end

    window_pos_tracker #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ROW_SIZE    (ROW_SIZE),
        .COLUMN_SIZE (COLUMN_SIZE),
        .STRIDE      (STRIDE)
    ) u_tracker (
        .clock            (clock),
        .reset            (reset),
        .clear            (clear),
        .beat             (buf_data_valid),
        .completes_window (win_in.valid),
        .win_row          (win_in.row),
        .win_col          (win_in.col)
    );

    // Coordinates only move with a valid window, so the last stage holds them between windows.
    genvar gi;
    generate
        for (gi = 0; gi < WIN_LATENCY; gi++) begin : g_win_dly
            win_beat_t src;
            win_beat_t stage_reg;
            if (gi == 0) begin : g_first
                assign src = win_in;
            end else begin : g_next
                assign src = g_win_dly[gi-1].stage_reg;
            end
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg.valid <= src.valid;
                    if (src.valid) begin
                        stage_reg.row <= src.row;
                        stage_reg.col <= src.col;
                    end
                end
            end
            assign win_busy[gi] = stage_reg.valid;
        end
    endgenerate

    assign win_valid = g_win_dly[WIN_LATENCY-1].stage_reg.valid;
    assign win_row   = g_win_dly[WIN_LATENCY-1].stage_reg.row;
    assign win_col   = g_win_dly[WIN_LATENCY-1].stage_reg.col;

endmodule

// File: doc/conv_window_controller.md
Name: conv_window_controller

Overview:
- Frame sequencer for Image_Buffer: on `start`, reads one frame of pixels in raster order from a synchronous pixel RAM and streams them into the buffer's data_in/data_in_valid.
- Tracks the row/column position of every pushed pixel.
- Emits an authoritative window-valid strobe with output coordinates. This suppresses row-straddling windows and applies stride, so the downstream MAC array acts only on legal kernel positions.
- Sits between the frame memory and the Image_Buffer → convolution engine.

Parameters:
- KERNEL_SIZE, 3, kernel edge length K (K ≤ ROW_SIZE, K ≤ COLUMN_SIZE).
- DATA_SIZE, 8, pixel width in bits.
- ROW_SIZE, 5, pixels per image row (image width W).
- COLUMN_SIZE, 5, rows per image (image height H).
- STRIDE, 1, window stride in both dimensions (≥1).
- WIN_LATENCY, 1, cycles from the buf_data_valid beat of a window's last pixel to Image_Buffer presenting that window; matched by an internal delay line.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pause  in  1  while high, no new RAM read is issued.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  $clog2(ROW_SIZE*COLUMN_SIZE)  raster address, r*W+c.
- mem_rd_data  in  DATA_SIZE  RAM data, valid the cycle after mem_rd_en.
- buf_data  out  DATA_SIZE  to Image_Buffer data_in.
- buf_data_valid  out  1  to Image_Buffer data_in_valid.
- win_valid  out  1  legal window present at Image_Buffer kernel_out this cycle.
- win_row  out  $clog2(COLUMN_SIZE)  output-map row of the current window.
- win_col  out  $clog2(ROW_SIZE)  output-map column of the current window.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and delay lines cleared. Reset mid-frame aborts immediately; in-flight beats are discarded, with no buf_data_valid or win_valid on the cycle after reset.
- States:
  - IDLE: `start`=1 → FEED. `start` is ignored in every other state.
  - FEED: each cycle with pause=0, drive mem_rd_en=1 and mem_addr = issue counter, then increment. After address W*H-1 is issued → DRAIN. With pause=1, mem_rd_en=0 and the counter holds.
  - DRAIN: no reads. When the read, data and win delay pipelines are all empty, pulse frame_done for one cycle and go → IDLE.
- Datapath timing:
  - mem_rd_data is registered into buf_data.
  - buf_data_valid is asserted exactly 2 cycles after the corresponding mem_rd_en.
  - pause never drops an in-flight beat.
- Position tracking, advanced on each buf_data_valid beat:
  - Pixel column c wraps W-1→0 and increments row r. r wraps H-1→0 at end of frame.
  - A beat completes a window when r≥K-1, c≥K-1, (r-K+1) mod STRIDE = 0 and (c-K+1) mod STRIDE = 0.
  - Stride phase is tracked with down-counters reloaded to STRIDE-1; no dividers.
  - win_row = (r-K+1)/STRIDE and win_col = (c-K+1)/STRIDE, kept as incrementing output counters.
- Window output: win_valid, win_row and win_col are delayed WIN_LATENCY cycles from the completing beat. When win_valid=0, win_row and win_col hold their last values.
- Window count per frame: ((H-K)/STRIDE+1)*((W-K)/STRIDE+1), integer division.
- Edge cases:
  - K=W: exactly one window per row-set.
  - start and pause both high in IDLE: enter FEED, issue nothing until pause falls.
  - start and reset together: reset wins.

Decomposition:
- Package cnn_ctrl_pkg holds:
  - the state enum (IDLE, FEED, DRAIN);
  - a clog2-based width function;
  - a window-count function used by the bench scoreboard.
- One sub-module, window_pos_tracker: row/column counters, stride phase counters and output coordinate counters. Inputs are beat strobe, clear and reset; outputs are completes_window, win_row and win_col.

Test Plan:
- Defaults (W=H=5, K=3, S=1); start high in cycle 0 →
  - mem_rd_en in cycles 1..25, addresses 0..24; buf_data_valid in cycles 3..27.
  - Exactly 9 win_valid pulses: first in cycle 16 at (0,0) from pixel 12, last in cycle 28 at (2,2).
  - frame_done in cycle 29; busy high in cycles 1..29.
- STRIDE=2, same frame → exactly 4 win_valid pulses, at (0,0),(0,1),(1,0),(1,1), from pixels 12, 14, 22 and 24.
- pause high for cycles 8..10 → no reads in those cycles; buf_data_valid shows a 3-cycle gap; still 25 beats and 9 windows with identical coordinates; frame_done in cycle 32.
- start pulsed again in cycle 10 mid-frame → ignored; total 25 reads and a single frame_done.
- reset in cycle 12 → all outputs 0 in cycle 13 and no stale win_valid. A fresh start then yields a full, correct 9-window frame.
- Two back-to-back frames (start in the cycle after frame_done) → second frame's coordinates restart at (0,0); 18 windows total.
